// File: rtl/cache_lookup_sequencer.sv
// Walks one access at a time through L1/L2/L3/memory with fixed probe
// latencies, issues fill strobes on lower-level hits and counts hit sources.
module cache_lookup_sequencer #(
  parameter int L1_LAT  = 1,
  parameter int L2_LAT  = 2,
  parameter int L3_LAT  = 4,
  parameter int MEM_LAT = 10,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic             clear_counts,
  output logic [31:0]      lookup_addr,
  input  logic             hit256,
  input  logic             hit512,
  input  logic             hit1024,
  output logic [2:0]       fill_en,
  output logic             resp_valid,
  output logic [1:0]       resp_level,
  output logic [CNT_W-1:0] hit_cnt_l1,
  output logic [CNT_W-1:0] hit_cnt_l2,
  output logic [CNT_W-1:0] hit_cnt_l3,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int M12 = (L1_LAT > L2_LAT) ? L1_LAT : L2_LAT;
  localparam int M3M = (L3_LAT > MEM_LAT) ? L3_LAT : MEM_LAT;
  localparam int MAXL = (M12 > M3M) ? M12 : M3M;
  localparam int TW = $clog2(MAXL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_P1, S_P2, S_P3, S_MEM, S_FILL, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       lvl_q, lvl_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] c1_q, c1_d, c2_q, c2_d;
  logic [CNT_W-1:0] c3_q, c3_d, cm_q, cm_d;
  logic             last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      lvl_q   <= '0;
      addr_q  <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      c3_q    <= '0;
      cm_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lvl_q   <= lvl_d;
      addr_q  <= addr_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      c3_q    <= c3_d;
      cm_q    <= cm_d;
    end
  end

  // timer counts down to zero; zero marks the sampling cycle
  assign last = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lvl_d   = lvl_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = S_P1;
          timer_d = TW'(L1_LAT - 1);
        end
      end
      S_P1: begin
        if (!last) begin
          timer_d = timer_q - TW'(1);
        end else if (hit256) begin
          lvl_d   = 2'd0;
          state_d = S_DONE;
        end else begin
          state_d = S_P2;
          timer_d = TW'(L2_LAT - 1);
        end
      end
      S_P2: begin
        if (!last) begin
          timer_d = timer_q - TW'(1);
        end else if (hit512) begin
          lvl_d   = 2'd1;
          state_d = S_FILL;
        end else begin
          state_d = S_P3;
          timer_d = TW'(L3_LAT - 1);
        end
      end
      S_P3: begin
        if (!last) begin
          timer_d = timer_q - TW'(1);
        end else if (hit1024) begin
          lvl_d   = 2'd2;
          state_d = S_FILL;
        end else begin
          lvl_d   = 2'd3;
          state_d = S_MEM;
          timer_d = TW'(MEM_LAT - 1);
        end
      end
      S_MEM: begin
        if (!last) timer_d = timer_q - TW'(1);
        else state_d = S_FILL;
      end
      S_FILL:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // clear has priority over the DONE increment
  always_comb begin
    c1_d = c1_q;
    c2_d = c2_q;
    c3_d = c3_q;
    cm_d = cm_q;
    if (clear_counts) begin
      c1_d = '0;
      c2_d = '0;
      c3_d = '0;
      cm_d = '0;
    end else if (state_q == S_DONE) begin
      unique case (lvl_q)
        2'd0: c1_d = c1_q + CNT_W'(1);
        2'd1: c2_d = c2_q + CNT_W'(1);
        2'd2: c3_d = c3_q + CNT_W'(1);
        2'd3: cm_d = cm_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_DONE);
    resp_level = (state_q == S_DONE) ? lvl_q : 2'd0;
    fill_en    = 3'b000;
    if (state_q == S_FILL) begin
      case (lvl_q)
        2'd1:    fill_en = 3'b001;
        2'd2:    fill_en = 3'b011;
        2'd3:    fill_en = 3'b111;
        default: fill_en = 3'b000;
      endcase
    end
  end

  assign lookup_addr = addr_q;
  assign hit_cnt_l1  = c1_q;
  assign hit_cnt_l2  = c2_q;
  assign hit_cnt_l3  = c3_q;
  assign miss_cnt    = cm_q;

endmodule
